key_direction_arbiter: RTL and testbench

- Upstream stage of the ball motion block; runs on frame_clk.
- Consumes the raw 4-slot keycode field of the USB HID keyboard report.
- Tracks press/release of the four direction keys (W/A/S/D) across frames and presents exactly one 8-bit keycode: the most recently pressed direction key still held.
- Also provides a one-frame press-event pulse and a saturating hold-duration count for downstream motion/speed logic.

---
 rtl/key_dir_pkg.sv | 41 ++++
 rtl/key_recency_stack.sv | 87 ++++++++
 rtl/key_direction_arbiter.sv | 169 ++++++++++++++++
 tb/tb_key_direction_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/key_dir_pkg.sv
// -----------------------------------------------------------------------------
// key_dir_pkg
// Shared definitions for the direction-key arbiter: HID keycodes for the
// W/A/S/D direction keys, the 2-bit key identifier, the recency-stack entry
// layout and a helper that maps a key identifier back to its HID keycode.
// Key identifiers double as bit positions in the 4-bit pressed/new/release
// masks (W = bit 0, A = bit 1, S = bit 2, D = bit 3).
// -----------------------------------------------------------------------------
package key_dir_pkg;

    localparam logic [7:0] KEY_W_CODE = 8'h1A;
    localparam logic [7:0] KEY_A_CODE = 8'h04;
    localparam logic [7:0] KEY_S_CODE = 8'h16;
    localparam logic [7:0] KEY_D_CODE = 8'h07;
    localparam logic [7:0] KEY_NONE   = 8'h00;
    localparam logic [7:0] HID_ERR    = 8'h01;

    typedef enum logic [1:0] {
        KID_W = 2'd0,
        KID_A = 2'd1,
        KID_S = 2'd2,
        KID_D = 2'd3
    } key_id_t;

    typedef struct packed {
        logic    valid;
        key_id_t id;
    } stack_entry_t;

    function automatic logic [7:0] id_to_code(input key_id_t id);
        logic [7:0] code;
        case (id)
            KID_W:   code = KEY_W_CODE;
            KID_A:   code = KEY_A_CODE;
            KID_S:   code = KEY_S_CODE;
            default: code = KEY_D_CODE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_recency_stack.sv
// -----------------------------------------------------------------------------
// key_recency_stack
// Four-entry most-recently-pressed stack of direction keys (entry 0 = top).
// Each frame: released keys are removed and the survivors compacted upward
// keeping their order, then newly pressed keys are pushed on top in the order
// D, S, A, W so that W ends up highest when several arrive together.
//
// Ports:
//   frame_clk  in   frame-rate clock
//   Reset      in   synchronous, active-high; empties the stack
//   enable     in   1 = apply this frame's masks, 0 = hold the stack
//   new_mask   in   [3:0] keys newly pressed this frame (bit = key id)
//   rel_mask   in   [3:0] keys released this frame (bit = key id)
//   top_valid  out  top entry of the stack as it will be after this edge
//   top_id     out  key id of that top entry (meaningful when top_valid)
// -----------------------------------------------------------------------------
module key_recency_stack
    import key_dir_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [3:0] new_mask,
    input  logic [3:0] rel_mask,
    output logic       top_valid,
    output key_id_t    top_id
);

    stack_entry_t stack_q   [4];
    stack_entry_t after_rel [4];
    stack_entry_t pushed    [4];
    stack_entry_t stack_n   [4];

    // Remove released keys; surviving entries slide up in their original order.
    always_comb begin
        logic [2:0] fill;
        fill = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            after_rel[i] = '0;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (stack_q[i].valid && !rel_mask[stack_q[i].id]) begin
                after_rel[fill[1:0]] = stack_q[i];
                fill = fill + 3'd1;
            end
        end
    end

    // Push new keys D first, W last, so the fixed priority W > A > S > D
    // decides the top when presses coincide.
    always_comb begin
        logic [1:0] kid;
        for (int unsigned i = 0; i < 4; i++) begin
            pushed[i] = after_rel[i];
        end
        for (int unsigned n = 0; n < 4; n++) begin
            kid = 2'(3 - n);
            if (new_mask[kid]) begin
                pushed[3] = pushed[2];
                pushed[2] = pushed[1];
                pushed[1] = pushed[0];
                pushed[0].valid = 1'b1;
                pushed[0].id    = key_id_t'(kid);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            stack_n[i] = enable ? pushed[i] : stack_q[i];
        end
    end

    always_ff @(posedge frame_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (Reset) begin
                stack_q[i] <= '0;
            end else begin
                stack_q[i] <= stack_n[i];
            end
        end
    end

    assign top_valid = stack_n[0].valid;
    assign top_id    = stack_n[0].id;

endmodule

// File: rtl/key_direction_arbiter.sv
// -----------------------------------------------------------------------------
// key_direction_arbiter
// Turns the raw 4-slot HID keycode field into a single direction keycode: the
// most recently pressed W/A/S/D key that is still held. Also produces a
// one-frame press-event pulse and a saturating hold-duration count.
// A report carrying HID error code 0x01 in any slot is ignored for that frame
// (state holds, no event, hold count keeps running).
//
// Optional build macro:
//   KEY_DIRECTION_REPEAT_EN  adds auto-repeat pulses on key_event: first at
//                            REPEAT_DELAY frames of hold, then every
//                            REPEAT_PERIOD frames.
//
// Ports:
//   frame_clk    in   frame-rate clock (vsync derived)
//   Reset        in   synchronous, active-high
//   keycode_in   in   [31:0] four HID keycode slots, slot i = [8i+7:8i]
//   keycode      out  [7:0] arbitrated direction keycode (0x00 = none)
//   key_event    out  one-frame pulse on a new nonzero keycode (and repeats)
//   hold_frames  out  [HOLD_W-1:0] frames current keycode has been output
// -----------------------------------------------------------------------------
module key_direction_arbiter
    import key_dir_pkg::*;
#(
    parameter int unsigned HOLD_W        = 8,
    parameter int unsigned REPEAT_DELAY  = 30,
    parameter int unsigned REPEAT_PERIOD = 6
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [31:0]       keycode_in,
    output logic [7:0]        keycode,
    output logic              key_event,
    output logic [HOLD_W-1:0] hold_frames
);

    logic [3:0]        pressed;
    logic [3:0]        prev_q;
    logic [3:0]        new_mask;
    logic [3:0]        rel_mask;
    logic              report_err;
    logic              top_valid;
    key_id_t           top_id;
    logic [7:0]        keycode_n;
    logic              changed;
    logic              repeat_pulse;
    logic              event_n;
    logic [HOLD_W-1:0] hold_n;

    // Slot decode: duplicates collapse into one mask bit, foreign codes drop out.
    always_comb begin
        logic [7:0] slot;
        pressed    = '0;
        report_err = 1'b0;
        for (int unsigned s = 0; s < 4; s++) begin
            slot = keycode_in[8*s +: 8];
            if (slot == HID_ERR)    report_err = 1'b1;
            if (slot == KEY_W_CODE) pressed[KID_W] = 1'b1;
            if (slot == KEY_A_CODE) pressed[KID_A] = 1'b1;
            if (slot == KEY_S_CODE) pressed[KID_S] = 1'b1;
            if (slot == KEY_D_CODE) pressed[KID_D] = 1'b1;
        end
    end

    assign new_mask = pressed & ~prev_q;
    assign rel_mask = ~pressed & prev_q;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            prev_q <= '0;
        end else if (!report_err) begin
            prev_q <= pressed;
        end
    end

    key_recency_stack u_stack (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .enable    (!report_err),
        .new_mask  (new_mask),
        .rel_mask  (rel_mask),
        .top_valid (top_valid),
        .top_id    (top_id)
    );

    always_comb begin
        keycode_n = keycode;
        if (!report_err) begin
            keycode_n = top_valid ? id_to_code(top_id) : KEY_NONE;
        end
    end

    assign changed = (keycode_n != keycode) && (keycode_n != KEY_NONE);

    always_comb begin
        hold_n = hold_frames;
        if (keycode_n == KEY_NONE) begin
            hold_n = '0;
        end else if (changed) begin
            hold_n = HOLD_W'(1);
        end else if (hold_frames != '1) begin
            hold_n = hold_frames + HOLD_W'(1);
        end
    end

`ifdef KEY_DIRECTION_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_n;
    logic             rpt_armed;
    logic             rpt_armed_n;

    // The counter mirrors hold_frames until the first repeat, then restarts
    // per period; it runs on its own so saturation of hold_frames is irrelevant.
    // Ignored (error) frames still advance it but cannot emit a pulse.
    always_comb begin
        logic [RPT_W-1:0] inc;
        inc          = rpt_cnt + RPT_W'(1);
        rpt_cnt_n    = inc;
        rpt_armed_n  = rpt_armed;
        repeat_pulse = 1'b0;
        if (keycode_n == KEY_NONE) begin
            rpt_cnt_n   = '0;
            rpt_armed_n = 1'b0;
        end else if (changed) begin
            rpt_cnt_n   = RPT_W'(1);
            rpt_armed_n = 1'b0;
        end else if (!rpt_armed && inc == RPT_W'(REPEAT_DELAY)) begin
            repeat_pulse = !report_err;
            rpt_cnt_n    = '0;
            rpt_armed_n  = 1'b1;
        end else if (rpt_armed && inc == RPT_W'(REPEAT_PERIOD)) begin
            repeat_pulse = !report_err;
            rpt_cnt_n    = '0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt_n;
            rpt_armed <= rpt_armed_n;
        end
    end
`else
    logic [63:0] unused_repeat_cfg;
    assign unused_repeat_cfg = {REPEAT_DELAY, REPEAT_PERIOD};
    assign repeat_pulse      = 1'b0;
`endif

    assign event_n = changed || repeat_pulse;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            keycode     <= KEY_NONE;
            key_event   <= 1'b0;
            hold_frames <= '0;
        end else begin
            keycode     <= keycode_n;
            key_event   <= event_n;
            hold_frames <= hold_n;
        end
    end

endmodule

// File: tb/tb_key_direction_arbiter.sv
module tb_key_direction_arbiter;

    localparam int HOLD_W = 8;
    localparam int RDELAY = 30;
    localparam int RPER   = 6;
    localparam int HMAX   = (1 << HOLD_W) - 1;

    logic              frame_clk = 1'b0;
    logic              Reset     = 1'b1;
    logic [31:0]       keycode_in = '0;
    logic [7:0]        keycode;
    logic              key_event;
    logic [HOLD_W-1:0] hold_frames;

    int total = 0;
    int bad   = 0;

    key_direction_arbiter #(
        .HOLD_W        (HOLD_W),
        .REPEAT_DELAY  (RDELAY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode_in  (keycode_in),
        .keycode     (keycode),
        .key_event   (key_event),
        .hold_frames (hold_frames)
    );

    always #5 frame_clk = ~frame_clk;

    // ---------------- behavioural model ----------------
    // Held keys kept in a queue, most recent first; id 0..3 = W, A, S, D.
    int   stk[$];
    bit   mprev[4];
    int   exp_code = 0;
    bit   exp_ev   = 0;
    int   exp_hold = 0;
    int   held_n   = 0;   // uncapped frames the current code has been output
    bit   model_ok = 0;

    function automatic int code_of(input int id);
        case (id)
            0: return 'h1A;
            1: return 'h04;
            2: return 'h16;
            default: return 'h07;
        endcase
    endfunction

    always @(posedge frame_clk) begin
        bit pr[4];
        bit err;
        int b, nc;
        bit chg;
        if (Reset) begin
            stk.delete();
            for (int k = 0; k < 4; k++) mprev[k] = 0;
            exp_code = 0; exp_ev = 0; exp_hold = 0; held_n = 0;
            model_ok = 1;
        end else begin
            err = 0;
            for (int k = 0; k < 4; k++) pr[k] = 0;
            for (int s = 0; s < 4; s++) begin
                b = int'((keycode_in >> (8*s)) & 32'hFF);
                if (b == 1) err = 1;
                for (int k = 0; k < 4; k++) if (b == code_of(k)) pr[k] = 1;
            end
            if (!err) begin
                for (int k = 0; k < 4; k++)
                    if (mprev[k] && !pr[k])
                        for (int i = 0; i < stk.size(); i++)
                            if (stk[i] == k) begin stk.delete(i); break; end
                for (int k = 3; k >= 0; k--)
                    if (pr[k] && !mprev[k]) stk.push_front(k);
                for (int k = 0; k < 4; k++) mprev[k] = pr[k];
                nc = (stk.size() > 0) ? code_of(stk[0]) : 0;
            end else begin
                nc = exp_code;
            end
            chg = (nc != 0) && (nc != exp_code);
            if (nc == 0) held_n = 0;
            else if (chg) held_n = 1;
            else held_n = held_n + 1;
            exp_hold = (held_n > HMAX) ? HMAX : held_n;
            exp_ev = chg;
`ifdef KEY_DIRECTION_REPEAT_EN
            if (!err && nc != 0 && !chg &&
                (held_n == RDELAY || (held_n > RDELAY && (held_n - RDELAY) % RPER == 0)))
                exp_ev = 1;
`endif
            exp_code = nc;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge frame_clk) begin
        if (model_ok) begin
            total++;
            if (int'(keycode) !== exp_code || key_event !== exp_ev || int'(hold_frames) !== exp_hold) begin
                bad++;
                $display("FAIL cycle_compare t=%0t got code=%h ev=%b hold=%0d exp code=%h ev=%b hold=%0d",
                         $time, keycode, key_event, hold_frames, exp_code[7:0], exp_ev, exp_hold);
            end
        end
    end

    // ---------------- directed stimulus + literal checks ----------------
    task automatic frame(input logic [31:0] kc);
        keycode_in = kc;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk3(input string name, input int c, input int e, input int h);
        chk({name, "_code"}, int'(keycode), c);
        chk({name, "_event"}, int'(key_event), e);
        chk({name, "_hold"}, int'(hold_frames), h);
    endtask

    int ev_holds[$];
    int exp_holds[$];

    initial begin
        Reset = 1'b1;
        frame(32'h0);
        frame(32'h0);
        chk3("reset", 'h00, 0, 0);
        Reset = 1'b0;

        frame(32'h0000001A); chk3("w_press", 'h1A, 1, 1);
        frame(32'h0000001A); chk3("w_hold", 'h1A, 0, 2);
        frame(32'h0000041A); chk3("a_over_w", 'h04, 1, 1);
        frame(32'h0000001A); chk3("a_release", 'h1A, 1, 1);
        frame(32'h00000000); chk3("all_up", 'h00, 0, 0);

        frame(32'h0000071A); chk3("wd_same_frame", 'h1A, 1, 1);
        frame(32'h00000007); chk3("w_release_d", 'h07, 1, 1);
        frame(32'h01010101); chk3("err_report", 'h07, 0, 2);
        frame(32'h00000000); chk3("rollover_zero", 'h00, 0, 0);

        frame(32'h00000004); chk3("a_first", 'h04, 1, 1);
        frame(32'h00000000); chk3("a_gap", 'h00, 0, 0);
        frame(32'h00000004); chk3("a_again", 'h04, 1, 1);
        frame(32'h16000416); chk3("dup_s_new", 'h16, 1, 1);
        frame(32'h2C1A1A00); chk3("dup_w_foreign", 'h1A, 1, 1);
        frame(32'h00000000);

        frame(32'h00000016); chk3("s_press", 'h16, 1, 1);
        for (int i = 1; i < 300; i++) frame(32'h00000016);
        chk("s_sat_code", int'(keycode), 'h16);
        chk("s_sat_hold", int'(hold_frames), 255);
        Reset = 1'b1;
        frame(32'h00000016); chk3("mid_reset", 'h00, 0, 0);
        Reset = 1'b0;
        frame(32'h00000016); chk3("after_reset", 'h16, 1, 1);

        frame(32'h00000000);
        for (int i = 0; i < 45; i++) begin
            frame(32'h00000004);
            if (key_event === 1'b1) ev_holds.push_back(int'(hold_frames));
        end
`ifdef KEY_DIRECTION_REPEAT_EN
        exp_holds = '{1, 30, 36, 42};
`else
        exp_holds = '{1};
`endif
        chk("repeat_count", ev_holds.size(), exp_holds.size());
        for (int i = 0; i < exp_holds.size(); i++)
            chk("repeat_at_hold", (i < ev_holds.size()) ? ev_holds[i] : -1, exp_holds[i]);

        frame(32'h00000000);
        @(negedge frame_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
